// File: rtl/sm_driver.sv
// sm_driver: drives a 4-state receiver (S0..S3) to a requested state with a
// pulse stream on x. A shadow copy of the receiver is advanced with the same
// x every cycle, so the controller always knows where the receiver is.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-low reset
//   i_start      request; sampled only when idle
//   i_target     requested receiver state, latched on an accepted start
//   o_x          pulse stream to the receiver (high in PULSE)
//   o_busy       high in CHECK, PULSE and GAP
//   o_done       one-cycle completion strobe
//   o_shadow     registered model of the receiver state
//   o_y_pred     predicted receiver output (shadow is S1 or S3)
//   o_pulse_cnt  pulses issued in the current or most recent transaction
module sm_driver #(
  parameter int unsigned GAP = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_start,
  input  logic [1:0] i_target,
  output logic       o_x,
  output logic       o_busy,
  output logic       o_done,
  output logic [1:0] o_shadow,
  output logic       o_y_pred,
  output logic [1:0] o_pulse_cnt
);

  typedef enum logic [2:0] {StIdle, StCheck, StPulse, StGap, StDone} state_t;

  // Gap counter counts down to zero, so it is loaded with GAP-1.
  localparam logic [3:0] GapLoad = (GAP == 0) ? 4'd0 : 4'(GAP - 1);

  state_t     r_state;
  logic [1:0] r_shadow;
  logic [1:0] r_target;
  logic [1:0] r_pulse_cnt;
  logic [3:0] r_gap_cnt;

  logic       w_x;
  logic [1:0] w_sn;

  assign w_x = (r_state == StPulse);

  // Receiver next-state function; x=0 in S3 falls back to S1.
  always_comb begin
    w_sn = r_shadow;
    unique case (r_shadow)
      2'd0: w_sn = w_x ? 2'd1 : 2'd0;
      2'd1: w_sn = w_x ? 2'd2 : 2'd1;
      2'd2: w_sn = w_x ? 2'd3 : 2'd2;
      2'd3: w_sn = w_x ? 2'd0 : 2'd1;
      default: w_sn = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= StIdle;
      r_shadow    <= 2'd0;
      r_target    <= 2'd0;
      r_pulse_cnt <= 2'd0;
      r_gap_cnt   <= 4'd0;
    end else begin
      r_shadow <= w_sn;
      case (r_state)
        StIdle: begin
          if (i_start) begin
            r_target    <= i_target;
            r_pulse_cnt <= 2'd0;
            r_state     <= StCheck;
          end
        end
        StCheck: begin
          r_state <= (w_sn == r_target) ? StDone : StPulse;
        end
        StPulse: begin
          // Saturate rather than wrap; at most three pulses are ever needed.
          if (r_pulse_cnt != 2'd3) begin
            r_pulse_cnt <= r_pulse_cnt + 2'd1;
          end
          if (w_sn == r_target) begin
            r_state <= StDone;
          end else if (w_sn == 2'd3 || GAP == 0) begin
            // An idle cycle in S3 would knock the receiver back to S1.
            r_state <= StPulse;
          end else begin
            r_gap_cnt <= GapLoad;
            r_state   <= StGap;
          end
        end
        StGap: begin
          if (r_gap_cnt == 4'd0) begin
            r_state <= StPulse;
          end else begin
            r_gap_cnt <= r_gap_cnt - 4'd1;
          end
        end
        StDone: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign o_x         = w_x;
  assign o_busy      = (r_state == StCheck) || (r_state == StPulse) || (r_state == StGap);
  assign o_done      = (r_state == StDone);
  assign o_shadow    = r_shadow;
  assign o_y_pred    = (r_shadow == 2'd1) || (r_shadow == 2'd3);
  assign o_pulse_cnt = r_pulse_cnt;

endmodule
